inv_preproc_stream: RTL and testbench
=====================================

INV_PREPROC_STREAM -- requirements
Module: inv_preproc_stream

Interface
REQ-001 Parameter N, default 10, sample/symbol width in bits (2..16).
REQ-002 Parameter J, default 32, samples per block including reference (8..64).
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 ref_en  input  1  1 = first sample of each block is a raw reference; sampled at block start.
REQ-006 bypass  input  1  1 = no prediction, output = input symbol; sampled at block start.
REQ-007 s_valid  input  1  input symbol valid.
REQ-008 s_ready  output  1  block accepts symbol.
REQ-009 s_data  input  N  mapped residual symbol, or raw reference sample.
REQ-010 m_valid  output  1  output sample valid.
REQ-011 m_ready  input  1  downstream accepts sample.
REQ-012 m_data  output  N  reconstructed sample.
REQ-013 m_last  output  1  marks sample J of a block; valid with m_valid.
REQ-014 blk_cnt  output  16  completed-block count, wraps 0xFFFF->0.

Function
REQ-015 Transfer occurs on s_valid&&s_ready, or on m_valid&&m_ready; no other event changes state.
REQ-016 s_ready = !m_valid || m_ready (combinational); input accepted in the same cycle output is consumed.
REQ-017 Latency: accepted symbol appears on m_data with m_valid the next cycle; full throughput, one sample/cycle.
REQ-018 m_data/m_last/m_valid held stable while m_valid && !m_ready.
REQ-019 FSM states: REF, DATA; reset -> REF.
REQ-020 REF: on transfer latch ref_en->ref_q, bypass->byp_q; if ref_en, output = s_data and x_prev <= s_data; else process as DATA; sample index <= 1; go to DATA.
REQ-021 DATA: each transfer increments sample index; transfer of sample J (index J-1) asserts m_last for that sample, increments blk_cnt, returns to REF.
REQ-022 x_prev persists across blocks; with ref_en=0 the first sample predicts from previous block's last sample (0 after reset).
REQ-023 Unit-delay inverse: xmax = 2^N-1; theta = min(x_prev, xmax-x_prev); lower = (x_prev <= xmax-x_prev).
REQ-024 If s_data <= 2*theta: even -> d = +s_data/2; odd -> d = -(s_data+1)/2.
REQ-025 If s_data > 2*theta: lower -> x = s_data; else x = xmax - s_data.
REQ-026 Otherwise x = x_prev + d computed in N+2 bits signed; result always within 0..xmax, no wrap required.
REQ-027 2*theta and comparisons evaluated at N+1 bits; no truncation.
REQ-028 byp_q=1: x = s_data, x_prev still updated to x.
REQ-029 x_prev <= x on every accepted symbol.
REQ-030 ref_en/bypass changes mid-block have no effect until next REF transfer.

Reset
REQ-031 On reset: state=REF, m_valid=0, m_data=0, m_last=0, blk_cnt=0, x_prev=0, index=0, ref_q=0, byp_q=0.
REQ-032 Reset mid-block discards partial block and pending output; next transfer treated as block start.
REQ-033 Reset deassertion takes effect on next clk edge; no transfer in cycle reset is high.

Verification
REQ-034 N=10,J=32,ref_en=1: ref 512 then symbols 4,3 -> m_data 512,514,512 (theta 511 then 509).
REQ-035 x_prev=5, symbol 20 -> 20; x_prev=1000, symbol 100 -> 923; x_prev=0, symbol 0 -> 0.
REQ-036 32 back-to-back transfers -> m_last only on 32nd, blk_cnt 0->1, state REF; 33rd s_data treated as reference.
REQ-037 m_ready low 5 cycles with m_valid=1 -> s_ready=0, m_data stable, no x_prev change; resume without loss/duplication.
REQ-038 bypass=1 at block start, toggled to 0 mid-block -> all 32 outputs equal inputs; next block predicts.
REQ-039 Reset asserted after sample 10 -> m_valid=0, blk_cnt unchanged, next symbol taken as reference with ref_en=1.

Source files
------------

// File: rtl/inv_preproc_stream.sv
// Streaming unit-delay inverse predictor. Each accepted symbol is turned back into a sample,
// either as a raw block reference, as a bypass copy, or by adding a decoded residual to x_prev.
module inv_preproc_stream #(
  parameter int N = 10,
  parameter int J = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ref_en,
  input  logic         bypass,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [N-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [N-1:0] m_data,
  output logic         m_last,
  output logic [15:0]  blk_cnt
);

  localparam int IW = $clog2(J);
  localparam logic [N-1:0] XMAX = '1;

  typedef enum logic {ST_REF, ST_DATA} state_t;

  state_t         state;
  logic [N-1:0]   x_prev;
  logic [IW-1:0]  idx;
  logic           byp_q;

  logic           s_xfer;
  logic [N:0]     xp_w, comp_w, theta_w, two_theta_w, s_w, mag_w;
  logic [N+1:0]   sum_w;
  logic           lower_w, use_raw;
  logic [N-1:0]   pred_w, x_w;

  assign s_ready = !m_valid || m_ready;
  assign s_xfer  = s_valid && s_ready;

  always_comb begin
    xp_w        = {1'b0, x_prev};
    comp_w      = {1'b0, XMAX} - xp_w;
    lower_w     = (xp_w <= comp_w);
    theta_w     = lower_w ? xp_w : comp_w;
    two_theta_w = theta_w << 1;
    s_w         = {1'b0, s_data};
    // Odd symbols map to negative residuals of magnitude (s+1)/2.
    mag_w       = (s_w + (N+1)'(s_data[0])) >> 1;
    sum_w       = s_data[0] ? ({1'b0, xp_w} - {1'b0, mag_w})
                            : ({1'b0, xp_w} + {1'b0, mag_w});
    if (s_w <= two_theta_w)
      pred_w = sum_w[N-1:0];
    else
      pred_w = lower_w ? s_data : (XMAX - s_data);
    // Mode inputs are only looked at on the block's first transfer.
    if (state == ST_REF)
      use_raw = ref_en || bypass;
    else
      use_raw = byp_q;
    x_w = use_raw ? s_data : pred_w;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_REF;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      blk_cnt <= '0;
      x_prev  <= '0;
      idx     <= '0;
      byp_q   <= 1'b0;
    end else if (s_xfer) begin
      m_valid <= 1'b1;
      m_data  <= x_w;
      x_prev  <= x_w;
      if (state == ST_REF) begin
        byp_q  <= bypass;
        idx    <= IW'(1);
        state  <= ST_DATA;
        m_last <= 1'b0;
      end else if (idx == IW'(J-1)) begin
        m_last  <= 1'b1;
        blk_cnt <= blk_cnt + 16'd1;
        idx     <= '0;
        state   <= ST_REF;
      end else begin
        idx    <= idx + IW'(1);
        m_last <= 1'b0;
      end
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inv_preproc_stream.sv
// Bench for inv_preproc_stream: directed vector table, corner sequences and random traffic,
// all checked against an arithmetic model of the inverse mapping and block framing.
module tb_inv_preproc_stream;
  localparam int N = 10;
  localparam int J = 32;
  localparam int XMAX = (1 << N) - 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         ref_en = 1'b0, bypass = 1'b0, s_valid = 1'b0, m_ready = 1'b0;
  logic         s_ready, m_valid, m_last;
  logic [N-1:0] s_data = '0;
  logic [N-1:0] m_data;
  logic [15:0]  blk_cnt;

  inv_preproc_stream #(.N(N), .J(J)) dut (
    .clk(clk), .reset(reset), .ref_en(ref_en), .bypass(bypass),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .blk_cnt(blk_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  // model: previous sample, samples taken in current block (0 = block start), bypass mode, blocks
  int mx_prev, mpos, mbyp, mblk;
  bit ev, el;
  int ed;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int pred(input int xp, input int s);
    int theta;
    theta = (xp < XMAX - xp) ? xp : XMAX - xp;
    if (s <= 2 * theta) return (s % 2 == 0) ? xp + s / 2 : xp - (s + 1) / 2;
    return (xp <= XMAX - xp) ? s : XMAX - s;
  endfunction

  task automatic model_reset();
    mx_prev = 0; mpos = 0; mbyp = 0; mblk = 0; ev = 0; el = 0; ed = 0;
  endtask

  task automatic cycle(input bit sv, input int sd, input bit mr, input bit re, input bit bp);
    bit rdy, xin;
    int x;
    @(negedge clk);
    s_valid = sv; s_data = sd[N-1:0]; m_ready = mr; ref_en = re; bypass = bp;
    #1;
    rdy = !ev || mr;
    check("s_ready", int'(s_ready), int'(rdy));
    xin = sv && rdy;
    @(posedge clk); #1;
    if (xin) begin
      if (mpos == 0) begin
        mbyp = bp;
        x = (re || bp) ? sd : pred(mx_prev, sd);
      end else begin
        x = mbyp ? sd : pred(mx_prev, sd);
      end
      mpos++;
      mx_prev = x;
      ev = 1; ed = x; el = (mpos == J);
      if (el) begin mpos = 0; mblk = (mblk + 1) % 65536; end
    end else if (ev && mr) begin
      ev = 0; el = 0;
    end
    check("m_valid", int'(m_valid), int'(ev));
    if (ev) begin
      check("m_data", int'(m_data), ed);
      check("m_last", int'(m_last), int'(el));
    end
    check("blk_cnt", int'(blk_cnt), mblk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; s_valid = 1'b1; m_ready = 1'b1; ref_en = 1'b0; s_data = N'(123);
    @(posedge clk); #1;
    model_reset();
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_m_data", int'(m_data), 0);
    check("rst_m_last", int'(m_last), 0);
    check("rst_blk_cnt", int'(blk_cnt), 0);
    @(negedge clk);
    reset = 1'b0; s_valid = 1'b0;
  endtask

  typedef struct { int sd; bit re; int exp; } vec_t;
  vec_t tbl[9];

  initial begin
    int held, sd;
    tbl = '{'{512, 1'b1, 512}, '{4, 1'b1, 514}, '{3, 1'b1, 512},
            '{1013, 1'b0, 5}, '{20, 1'b0, 20}, '{1000, 1'b0, 1000},
            '{100, 1'b0, 923}, '{1023, 1'b0, 0}, '{0, 1'b0, 0}};
    model_reset();
    do_reset();
    check("rst_s_ready", int'(s_ready), 1);

    foreach (tbl[i]) begin
      cycle(1'b1, tbl[i].sd, 1'b1, tbl[i].re, 1'b0);
      check($sformatf("vec%0d", i), int'(m_data), tbl[i].exp);
    end

    // tenth sample, then reset mid-block; next block restarts with a reference
    cycle(1'b1, 7, 1'b1, 1'b0, 1'b0);
    do_reset();
    check("rst_mid_blk", int'(blk_cnt), 0);
    cycle(1'b1, 300, 1'b1, 1'b1, 1'b0);
    check("ref_after_rst", int'(m_data), 300);

    for (int i = 1; i < J; i++) cycle(1'b1, int'($urandom_range(0, XMAX)), 1'b1, 1'b1, 1'b1);
    check("last_on_32", int'(m_last), 1);
    check("blk_cnt_one", int'(blk_cnt), 1);
    cycle(1'b1, 77, 1'b1, 1'b1, 1'b0);
    check("ref_33rd", int'(m_data), 77);
    check("ref_33rd_last", int'(m_last), 0);

    // downstream stall with input pending
    cycle(1'b1, 9, 1'b1, 1'b0, 1'b0);
    held = ed;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, int'($urandom_range(0, XMAX)), 1'b0, 1'b0, 1'b0);
      check("stall_ready", int'(s_ready), 0);
      check("stall_hold", int'(m_data), held);
    end
    for (int i = 0; i < 6; i++) cycle(1'b1, int'($urandom_range(0, XMAX)), 1'b1, 1'b0, 1'b0);
    while (mpos != 0) cycle(1'b1, int'($urandom_range(0, XMAX)), 1'b1, 1'b0, 1'b0);

    // bypass latched at block start, dropped mid-block without effect
    for (int i = 0; i < J; i++) begin
      sd = int'($urandom_range(0, XMAX));
      cycle(1'b1, sd, 1'b1, 1'b0, (i < 10));
      check("bypass_copy", int'(m_data), sd);
    end
    check("bypass_blk_end", int'(m_last), 1);
    for (int i = 0; i < 4; i++) cycle(1'b1, int'($urandom_range(0, XMAX)), 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, XMAX)), $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
